// File: rtl/mc_controller.sv
// Multicycle MIPS sequencer: Moore FSM stepping fetch/decode/execute/memory/writeback with a
// memory handshake and timeout. Define MC_JAL_EN to add the single-cycle jal state.
module mc_controller #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       regwrite,
  output logic       illegal,
  output logic       mem_err,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  state_t          state_q;
  state_t          state_d;
  logic [TO_W-1:0] tocnt;
  logic            mem_state;
  logic            to_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Wait counter restarts whenever the FSM changes state or gives up on a memory access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            tocnt <= '0;
    else if (state_d != state_q || to_hit) tocnt <= '0;
    else if (!mem_ready && TIMEOUT != 0)   tocnt <= tocnt + TO_W'(1);
  end

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign to_hit    = (TIMEOUT != 0) && mem_state && !mem_ready && (tocnt == TO_LIM);
  assign state     = state_q;

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = 3'b000;
    regdst     = 2'b00;
    memtoreg   = 2'b00;
    regwrite   = 1'b0;
    illegal    = 1'b0;
    mem_err    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        // The fetch strobes are gated by reset so nothing is written while it is held.
        if (mem_ready) begin
          irwrite = reset;
          pcwrite = reset;
          state_d = S_DECODE;
        end else if (to_hit) begin
          mem_req = 1'b0;
          mem_err = 1'b1;
        end
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
        case (op)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MC_JAL_EN
          OP_JAL:       state_d = S_JAL;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        state_d    = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (to_hit) begin
          mem_req = 1'b0;
          mem_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMWB: begin
        memtoreg = 2'b01;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (to_hit) begin
          mem_req  = 1'b0;
          memwrite = 1'b0;
          mem_err  = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXEC: begin
        alusrca = 1'b1;
        state_d = S_ALUWB;
        case (funct)
          6'b100000: alucontrol = ALU_ADD;
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        regdst   = 2'b01;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
        state_d    = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
`ifdef MC_JAL_EN
      // PC already holds PC+4 from fetch, so $31 is written from the PC in the same cycle.
      S_JAL: begin
        pcsrc    = 2'b10;
        pcwrite  = 1'b1;
        regdst   = 2'b10;
        memtoreg = 2'b10;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
`ifndef MC_JAL_EN
    regdst[1]   = 1'b0;
    memtoreg[1] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected outputs are queued as stimulus is
// driven and popped at the falling edge. Runs with TIMEOUT = 4; honours MC_JAL_EN.
module tb_mc_controller;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BEQ    = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_JAL    = 4'd12;

  typedef struct packed {
    logic [3:0] state;
    logic       mem_req;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       illegal;
    logic       mem_err;
  } exp_t;

  typedef struct packed {
    logic       rdy;
    logic [5:0] op;
    logic [5:0] funct;
    exp_t       e;
  } cyc_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       mem_ready = 1'b1;
  logic       mem_req, memwrite, iord, irwrite, pcwrite, branch;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic [1:0] regdst, memtoreg;
  logic       regwrite, illegal, mem_err;
  logic [3:0] state;

  exp_t obs;
  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  mc_controller #(.TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcwrite(pcwrite), .branch(branch), .pcsrc(pcsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .alucontrol(alucontrol), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .illegal(illegal), .mem_err(mem_err), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, mem_req, memwrite, iord, irwrite, pcwrite, branch, pcsrc, alusrca,
                alusrcb, alucontrol, regdst, memtoreg, regwrite, illegal, mem_err};

  // Moore outputs each state is documented to drive; everything else is 0.
  function automatic exp_t base(input logic [3:0] s);
    exp_t e;
    e = '0;
    e.state = s;
    case (s)
      S_FETCH:  begin e.mem_req = 1; e.alusrcb = 2'b01; e.alucontrol = 3'b010; end
      S_DECODE: begin e.alusrcb = 2'b11; e.alucontrol = 3'b010; end
      S_MEMADR: begin e.alusrca = 1; e.alusrcb = 2'b10; e.alucontrol = 3'b010; end
      S_MEMRD:  begin e.mem_req = 1; e.iord = 1; end
      S_MEMWB:  begin e.memtoreg = 2'b01; e.regwrite = 1; end
      S_MEMWR:  begin e.mem_req = 1; e.memwrite = 1; e.iord = 1; end
      S_EXEC:   begin e.alusrca = 1; end
      S_ALUWB:  begin e.regdst = 2'b01; e.regwrite = 1; end
      S_BEQ:    begin e.alusrca = 1; e.alucontrol = 3'b110; e.pcsrc = 2'b01; e.branch = 1; end
      S_ADDIEX: begin e.alusrca = 1; e.alusrcb = 2'b10; e.alucontrol = 3'b010; end
      S_ADDIWB: begin e.regwrite = 1; end
      S_JUMP:   begin e.pcsrc = 2'b10; e.pcwrite = 1; end
      S_JAL:    begin e.pcsrc = 2'b10; e.pcwrite = 1; e.regdst = 2'b10;
                      e.memtoreg = 2'b10; e.regwrite = 1; end
      default:  e = '0;
    endcase
    return e;
  endfunction

  function automatic exp_t fetch_go();
    exp_t e;
    e = base(S_FETCH);
    e.irwrite = 1;
    e.pcwrite = 1;
    return e;
  endfunction

  function automatic exp_t timed_out(input logic [3:0] s);
    exp_t e;
    e = base(s);
    e.mem_req = 0;
    e.memwrite = 0;
    e.mem_err = 1;
    return e;
  endfunction

  function automatic exp_t with_illegal(input logic [3:0] s);
    exp_t e;
    e = base(s);
    e.illegal = 1;
    return e;
  endfunction

  function automatic exp_t exec_alu(input logic [2:0] alu);
    exp_t e;
    e = base(S_EXEC);
    e.alucontrol = alu;
    return e;
  endfunction

  function automatic cyc_t cyc(input logic r, input logic [5:0] o, input logic [5:0] f,
                               input exp_t e);
    cyc_t x;
    x.rdy = r;
    x.op = o;
    x.funct = f;
    x.e = e;
    return x;
  endfunction

  task automatic applyStimulus(input cyc_t c);
    mem_ready = c.rdy;
    op = c.op;
    funct = c.funct;
    sb.push_back(c.e);
  endtask

  task automatic test_reset();
    cyc_t plan[$];
    exp_t got, want;
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) plan.push_back(cyc(1'b1, 6'b000100, 6'd0, base(S_FETCH)));
    foreach (plan[i]) begin
      applyStimulus(plan[i]);
      @(negedge clk);
      got = obs; want = sb.pop_front(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL reset_hold cyc%0d got=%h want=%h", i, got, want);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    plan.delete();
    plan.push_back(cyc(1'b1, 6'b000100, 6'd0, fetch_go()));
    plan.push_back(cyc(1'b1, 6'b000100, 6'd0, base(S_DECODE)));
    plan.push_back(cyc(1'b1, 6'b000100, 6'd0, base(S_BEQ)));
    foreach (plan[i]) begin
      applyStimulus(plan[i]);
      @(negedge clk);
      got = obs; want = sb.pop_front(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL reset_release cyc%0d got=%h want=%h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    logic [2:0] alu [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b000};
    cyc_t plan[$];
    exp_t got, want;
    for (int k = 0; k < 6; k++) begin
      plan.push_back(cyc(1'b1, 6'b000000, fn[k], fetch_go()));
      plan.push_back(cyc(1'b1, 6'b000000, fn[k], base(S_DECODE)));
      if (k < 5) begin
        plan.push_back(cyc(1'b1, 6'b000000, fn[k], exec_alu(alu[k])));
        plan.push_back(cyc(1'b1, 6'b000000, fn[k], base(S_ALUWB)));
      end else begin
        plan.push_back(cyc(1'b1, 6'b000000, fn[k], with_illegal(S_EXEC)));
      end
    end
    foreach (plan[i]) begin
      applyStimulus(plan[i]);
      @(negedge clk);
      got = obs; want = sb.pop_front(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL rtype cyc%0d got=%h want=%h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    cyc_t plan[$];
    exp_t got, want;
    plan.push_back(cyc(1'b1, 6'b100011, 6'd0, fetch_go()));
    plan.push_back(cyc(1'b1, 6'b100011, 6'd0, base(S_DECODE)));
    plan.push_back(cyc(1'b1, 6'b100011, 6'd0, base(S_MEMADR)));
    for (int k = 0; k < 3; k++) plan.push_back(cyc(1'b0, 6'b100011, 6'd0, base(S_MEMRD)));
    plan.push_back(cyc(1'b1, 6'b100011, 6'd0, base(S_MEMRD)));
    plan.push_back(cyc(1'b1, 6'b100011, 6'd0, base(S_MEMWB)));
    foreach (plan[i]) begin
      applyStimulus(plan[i]);
      @(negedge clk);
      got = obs; want = sb.pop_front(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL lw cyc%0d got=%h want=%h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump();
    cyc_t plan[$];
    exp_t got, want;
    plan.push_back(cyc(1'b1, 6'b000100, 6'd0, fetch_go()));
    plan.push_back(cyc(1'b1, 6'b000100, 6'd0, base(S_DECODE)));
    plan.push_back(cyc(1'b1, 6'b000100, 6'd0, base(S_BEQ)));
    plan.push_back(cyc(1'b1, 6'b001000, 6'd0, fetch_go()));
    plan.push_back(cyc(1'b1, 6'b001000, 6'd0, base(S_DECODE)));
    plan.push_back(cyc(1'b1, 6'b001000, 6'd0, base(S_ADDIEX)));
    plan.push_back(cyc(1'b1, 6'b001000, 6'd0, base(S_ADDIWB)));
    plan.push_back(cyc(1'b1, 6'b000010, 6'd0, fetch_go()));
    plan.push_back(cyc(1'b1, 6'b000010, 6'd0, base(S_DECODE)));
    plan.push_back(cyc(1'b1, 6'b000010, 6'd0, base(S_JUMP)));
    plan.push_back(cyc(1'b1, 6'b111111, 6'd0, fetch_go()));
    plan.push_back(cyc(1'b1, 6'b111111, 6'd0, with_illegal(S_DECODE)));
    foreach (plan[i]) begin
      applyStimulus(plan[i]);
      @(negedge clk);
      got = obs; want = sb.pop_front(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL branch_jump cyc%0d got=%h want=%h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    cyc_t plan[$];
    exp_t got, want;
    // Store stalls until the counter reaches 4, then aborts with mem_err.
    plan.push_back(cyc(1'b1, 6'b101011, 6'd0, fetch_go()));
    plan.push_back(cyc(1'b1, 6'b101011, 6'd0, base(S_DECODE)));
    plan.push_back(cyc(1'b1, 6'b101011, 6'd0, base(S_MEMADR)));
    for (int k = 0; k < 4; k++) plan.push_back(cyc(1'b0, 6'b101011, 6'd0, base(S_MEMWR)));
    plan.push_back(cyc(1'b0, 6'b101011, 6'd0, timed_out(S_MEMWR)));
    // Same store, but mem_ready arrives exactly at the limit and wins.
    plan.push_back(cyc(1'b1, 6'b101011, 6'd0, fetch_go()));
    plan.push_back(cyc(1'b1, 6'b101011, 6'd0, base(S_DECODE)));
    plan.push_back(cyc(1'b1, 6'b101011, 6'd0, base(S_MEMADR)));
    for (int k = 0; k < 4; k++) plan.push_back(cyc(1'b0, 6'b101011, 6'd0, base(S_MEMWR)));
    plan.push_back(cyc(1'b1, 6'b101011, 6'd0, base(S_MEMWR)));
    // Fetch itself times out and retries in place.
    for (int k = 0; k < 4; k++) plan.push_back(cyc(1'b0, 6'b000100, 6'd0, base(S_FETCH)));
    plan.push_back(cyc(1'b0, 6'b000100, 6'd0, timed_out(S_FETCH)));
    plan.push_back(cyc(1'b1, 6'b000100, 6'd0, fetch_go()));
    plan.push_back(cyc(1'b1, 6'b000100, 6'd0, base(S_DECODE)));
    plan.push_back(cyc(1'b1, 6'b000100, 6'd0, base(S_BEQ)));
    foreach (plan[i]) begin
      applyStimulus(plan[i]);
      @(negedge clk);
      got = obs; want = sb.pop_front(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL timeout cyc%0d got=%h want=%h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jal();
    cyc_t plan[$];
    exp_t got, want;
    plan.push_back(cyc(1'b1, 6'b000011, 6'd0, fetch_go()));
`ifdef MC_JAL_EN
    plan.push_back(cyc(1'b1, 6'b000011, 6'd0, base(S_DECODE)));
    plan.push_back(cyc(1'b1, 6'b000011, 6'd0, base(S_JAL)));
`else
    plan.push_back(cyc(1'b1, 6'b000011, 6'd0, with_illegal(S_DECODE)));
`endif
    plan.push_back(cyc(1'b1, 6'b000100, 6'd0, fetch_go()));
    foreach (plan[i]) begin
      applyStimulus(plan[i]);
      @(negedge clk);
      got = obs; want = sb.pop_front(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL jal cyc%0d got=%h want=%h", i, got, want);
      end
      @(posedge clk); #1;
    end
    plan.delete();
    plan.push_back(cyc(1'b1, 6'b000100, 6'd0, base(S_DECODE)));
    plan.push_back(cyc(1'b1, 6'b000100, 6'd0, base(S_BEQ)));
    foreach (plan[i]) begin
      applyStimulus(plan[i]);
      @(negedge clk);
      got = obs; want = sb.pop_front(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL jal_after cyc%0d got=%h want=%h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    cyc_t plan[$];
    exp_t got, want;
    plan.push_back(cyc(1'b1, 6'b101011, 6'd0, fetch_go()));
    plan.push_back(cyc(1'b1, 6'b101011, 6'd0, base(S_DECODE)));
    plan.push_back(cyc(1'b1, 6'b101011, 6'd0, base(S_MEMADR)));
    plan.push_back(cyc(1'b0, 6'b101011, 6'd0, base(S_MEMWR)));
    plan.push_back(cyc(1'b0, 6'b101011, 6'd0, base(S_MEMWR)));
    foreach (plan[i]) begin
      applyStimulus(plan[i]);
      @(negedge clk);
      got = obs; want = sb.pop_front(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL async_pre cyc%0d got=%h want=%h", i, got, want);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    applyStimulus(cyc(1'b1, 6'b101011, 6'd0, base(S_FETCH)));
    #1;
    got = obs; want = sb.pop_front(); compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL async_abort got=%h want=%h", got, want);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    plan.delete();
    plan.push_back(cyc(1'b1, 6'b001000, 6'd0, fetch_go()));
    plan.push_back(cyc(1'b1, 6'b001000, 6'd0, base(S_DECODE)));
    foreach (plan[i]) begin
      applyStimulus(plan[i]);
      @(negedge clk);
      got = obs; want = sb.pop_front(); compared++;
      if (got !== want) begin
        mismatched++;
        $display("[TB] FAIL async_post cyc%0d got=%h want=%h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_branch_jump();
    test_timeout();
    test_jal();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
